conv_stream_driver: RTL
=======================

Name: conv_stream_driver

Overview:
- Host-side initiator for the convolution filter's load/write interface.
- On start, it streams 9 stored coefficients on coeff_load/coeff_in, then streams an IMG_W x IMG_H frame from a pixel memory on data_load/data_i.
- It captures every data_o beat qualified by data_write into an output memory, and reports done or timeout.
- It sits between the frame buffers and convolution_filter_module.

Parameters:
- IMG_W, 8, frame width in pixels.
- IMG_H, 8, frame height in pixels.
- ADDR_W, 6, pixel/output memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.
- TIMEOUT, 64, maximum idle cycles without data_write in DRAIN before an error is flagged.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  coefficient register write strobe.
- cfg_addr  in  4  coefficient index 0..8, row-major; values 9..15 are ignored.
- cfg_data  in  8  coefficient value.
- start  in  1  single-cycle start request.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at completion.
- timeout_err  out  1  sticky error flag; cleared by the next accepted start.
- pix_rd_en  out  1  pixel memory read enable.
- pix_rd_addr  out  ADDR_W  pixel read address.
- pix_rd_data  in  8  read data, valid exactly 1 cycle after pix_rd_en.
- coeff_load  out  1  filter coefficient strobe.
- coeff_in  out  8  coefficient byte.
- data_load  out  1  filter pixel strobe.
- data_i  out  8  pixel byte.
- data_o  in  8  filter output byte.
- data_write  in  1  filter output valid.
- out_we  out  1  output memory write enable.
- out_addr  out  ADDR_W  output write address.
- out_data  out  8  output write data.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0; coefficient registers are 0; counters are 0.
  - Reset mid-operation aborts immediately with no done pulse; the filter is left to its own reset.
- Definition: N = IMG_W*IMG_H.
- Config:
  - cfg_we with cfg_addr <= 8 writes coef[cfg_addr] only in IDLE.
  - cfg_we is ignored while busy.
- FSM states: IDLE, COEFF, DATA, DRAIN, DONE.
- IDLE:
  - start=1 moves to COEFF on the next cycle.
  - It also clears timeout_err and both counters (issue count, captured count out_cnt).
  - start in any other state is ignored.
- COEFF (9 cycles):
  - coeff_load=1 and coeff_in=coef[k] for k=0..8, in consecutive cycles.
  - After k=8, move to DATA.
- DATA:
  - pix_rd_en=1 with pix_rd_addr = 0..N-1, one address per cycle, no gaps.
  - A registered stage asserts data_load=1 with data_i=pix_rd_data one cycle after each read.
  - data_load is therefore high for exactly N consecutive cycles, starting the cycle after the first read.
  - Enter DRAIN in the cycle after the last data_load beat.
- Capture:
  - Active in COEFF, DATA and DRAIN.
  - out_we = data_write & active & (out_cnt < N), combinational.
  - out_data = data_o; out_addr = out_cnt.
  - out_cnt increments on each out_we.
  - Beats beyond N are dropped.
- DRAIN:
  - Move to DONE when out_cnt reaches N, including when it reaches N in the same cycle as entering DRAIN.
  - Idle counter: resets on each data_write and increments otherwise.
  - When the idle counter reaches TIMEOUT: set timeout_err=1 and move to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then return to IDLE.
- out_cnt reaching N while still in COEFF or DATA does not end the run; the pixel stream always completes.
- data_o/data_write outside the active states is ignored.
- A start coinciding with a cfg_we in IDLE: the write is applied and the run starts, using the new value.
- No backpressure: the filter must accept one beat per cycle.
- Total minimum latency from start to done: 1 + 9 + N + 1 + drain + 1 cycles.

Test Plan:
- Coefficient stream:
  - Stimulus: write coef = {1,2,3,4,5,6,7,8,9}, then pulse start.
  - Required: coeff_load high for 9 consecutive cycles starting 1 cycle after start; coeff_in reads 1..9 in order.
- Pixel stream:
  - Stimulus: pixel memory [a] = a for an 8x8 frame.
  - Required: pix_rd_addr 0..63 in contiguous cycles; data_load high 64 cycles; data_i = 0..63, each value one cycle behind its address.
- Capture with a loopback model:
  - Stimulus: model drives data_write=data_load and data_o=data_i delayed 3 cycles.
  - Required: out_addr 0..63 receives values 0..63; done pulses once; timeout_err=0.
- Timeout:
  - Stimulus: model emits only 60 data_write beats.
  - Required: 64 cycles after the last beat, timeout_err=1 and done pulses; out_cnt=60.
- Ignored inputs:
  - Stimulus: start and a cfg_we to coef[0]=0xFF, both issued mid-DATA.
  - Required: no restart; coef[0] unchanged on the next run.
  - Stimulus: a 65th data_write beat.
  - Required: out_we stays 0.
- Reset mid-run:
  - Stimulus: assert rst during DATA at pixel 20.
  - Required: next cycle all outputs 0, busy=0, no done pulse; coef registers 0; a new run completes normally.

Source files
------------

// File: rtl/conv_stream_driver.sv
// Host-side initiator for the convolution filter: streams 9 coefficients, then one frame of
// pixels, and captures the filter's output beats into an output memory.
module conv_stream_driver #(
  parameter int unsigned IMG_W   = 8,
  parameter int unsigned IMG_H   = 8,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_rd_addr,
  input  logic [7:0]        pix_rd_data,
  output logic              coeff_load,
  output logic [7:0]        coeff_in,
  output logic              data_load,
  output logic [7:0]        data_i,
  input  logic [7:0]        data_o,
  input  logic              data_write,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data
);

  localparam int unsigned N     = IMG_W * IMG_H;
  // One extra bit so the counters can hold N itself.
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0]  NCnt        = CntW'(N);
  localparam logic [CntW-1:0]  LastCoef    = CntW'(8);
  localparam logic [IdleW-1:0] TimeoutIdle = IdleW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StCoeff,
    StData,
    StDrain,
    StDone
  } state_e;

  state_e           state_q;
  logic [7:0]       coef_q [9];
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  out_cnt_q;
  logic [CntW-1:0]  out_cnt_nxt;
  logic [IdleW-1:0] idle_q;
  logic [IdleW-1:0] idle_nxt;
  logic             data_load_q;
  logic             active;

  always_comb begin
    active      = (state_q == StCoeff) || (state_q == StData) || (state_q == StDrain);
    busy        = active;
    done        = (state_q == StDone);
    out_we      = data_write && active && (out_cnt_q < NCnt);
    out_cnt_nxt = out_we ? out_cnt_q + 1'b1 : out_cnt_q;
    idle_nxt    = data_write ? '0 : idle_q + 1'b1;
    out_addr    = active ? out_cnt_q[ADDR_W-1:0] : '0;
    out_data    = out_we ? data_o : '0;
    pix_rd_en   = (state_q == StData) && (cnt_q < NCnt);
    pix_rd_addr = pix_rd_en ? cnt_q[ADDR_W-1:0] : '0;
    coeff_load  = (state_q == StCoeff);
    coeff_in    = coeff_load ? coef_q[cnt_q[3:0]] : '0;
    data_load   = data_load_q;
    // Memory read data lands one cycle after the address, aligned with data_load.
    data_i      = data_load_q ? pix_rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      idle_q      <= '0;
      data_load_q <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      data_load_q <= pix_rd_en;
      if (active) begin
        out_cnt_q <= out_cnt_nxt;
      end
      unique case (state_q)
        StIdle: begin
          if (cfg_we && (cfg_addr <= 4'd8)) begin
            coef_q[cfg_addr] <= cfg_data;
          end
          if (start) begin
            state_q     <= StCoeff;
            cnt_q       <= '0;
            out_cnt_q   <= '0;
            idle_q      <= '0;
            timeout_err <= 1'b0;
          end
        end
        StCoeff: begin
          if (cnt_q == LastCoef) begin
            cnt_q   <= '0;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q < NCnt) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // Leave only once the final pixel beat has been presented to the filter.
          if ((cnt_q == NCnt) && data_load_q) begin
            state_q <= StDrain;
            idle_q  <= '0;
          end
        end
        StDrain: begin
          idle_q <= idle_nxt;
          if (out_cnt_nxt == NCnt) begin
            state_q <= StDone;
          end else if (idle_nxt == TimeoutIdle) begin
            timeout_err <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
